// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues word fetches on the code port, buffers the
// returned bytes and presents up to four of them per cycle to the decoder.
module prefetch_queue #(
  parameter int          DEPTH_WORDS   = 4,
  parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_code_vaild,
  input  logic        i_code_ready,
  output logic [31:0] o_code_address,
  input  logic [31:0] i_code_data_read,
  input  logic        i_flush,
  input  logic [31:0] i_flush_address,
  output logic [31:0] o_queue_data,
  output logic [2:0]  o_queue_count,
  input  logic [2:0]  i_consume
);

  localparam int CAP   = 4 * DEPTH_WORDS;
  localparam int PTR_W = $clog2(CAP);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [31:0]      fetch_addr;
  logic [31:0]      req_addr;
  logic [1:0]       skip;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       mem [CAP];

  logic [2:0] take;
  logic [2:0] wr_bytes;
  logic       do_write;
  logic       busy;

  assign busy           = (state == FETCH) || (state == DRAIN);
  assign o_code_vaild   = busy && !i_code_ready;
  assign o_code_address = req_addr;
  assign o_queue_count  = (count >= CNT_W'(4)) ? 3'd4 : count[2:0];

  always_comb begin
    take     = (i_consume > o_queue_count) ? o_queue_count : i_consume;
    do_write = (state == FETCH) && i_code_ready && !i_flush;
    wr_bytes = 3'd4 - {1'b0, skip};
  end

  // Lanes beyond the valid count read as zero so the reset view is all-zero.
  always_comb begin
    o_queue_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < o_queue_count)
        o_queue_data[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
    end
  end

  // Bytes below the skip offset belong to the part of the word before a
  // misaligned redirect target, so only lanes skip..3 are packed into the queue.
  always_ff @(posedge i_clock) begin
    if (do_write) begin
      for (int j = 0; j < 4; j++) begin
        if (2'(j) >= skip)
          mem[wr_ptr + PTR_W'(j) - PTR_W'(skip)] <= i_code_data_read[8*j +: 8];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      fetch_addr <= RESET_ADDRESS;
      req_addr   <= RESET_ADDRESS;
      skip       <= 2'd0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (i_flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= {i_flush_address[31:2], 2'b00};
      skip       <= i_flush_address[1:0];
      // An unanswered request must still be completed on the bus before redirecting.
      state      <= (busy && !i_code_ready) ? DRAIN : IDLE;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(take);
      count  <= count + (do_write ? CNT_W'(wr_bytes) : CNT_W'(0)) - CNT_W'(take);
      if (do_write) begin
        wr_ptr     <= wr_ptr + PTR_W'(wr_bytes);
        fetch_addr <= fetch_addr + 32'd4;
        skip       <= 2'd0;
      end
      case (state)
        IDLE: begin
          if (count <= CNT_W'(CAP - 4)) begin
            state    <= FETCH;
            req_addr <= fetch_addr;
          end
        end
        FETCH, DRAIN: begin
          if (i_code_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Testbench for prefetch_queue: directed scenarios followed by a randomized run
// checked against a byte-queue reference model.
module tb_prefetch_queue;

  localparam int CAP = 16;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_code_vaild;
  logic        i_code_ready = 1'b0;
  logic [31:0] o_code_address;
  logic [31:0] i_code_data_read = '0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_address = '0;
  logic [31:0] o_queue_data;
  logic [2:0]  o_queue_count;
  logic [2:0]  i_consume = '0;

  int checks = 0;
  int errors = 0;

  prefetch_queue #(.DEPTH_WORDS(4), .RESET_ADDRESS(32'hFFFF_FFF0)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .o_code_vaild     (o_code_vaild),
    .i_code_ready     (i_code_ready),
    .o_code_address   (o_code_address),
    .i_code_data_read (i_code_data_read),
    .i_flush          (i_flush),
    .i_flush_address  (i_flush_address),
    .o_queue_data     (o_queue_data),
    .o_queue_count    (o_queue_count),
    .i_consume        (i_consume)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (o_code_vaild !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (o_code_vaild !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_request_timeout: o_code_vaild=%b expected 1", tag, o_code_vaild);
    end
  endtask

  task automatic respond(input int lat, input logic [31:0] d, input logic [2:0] cons);
    repeat (lat) tick();
    i_code_ready     = 1'b1;
    i_code_data_read = d;
    i_consume        = cons;
    tick();
    i_code_ready = 1'b0;
    i_consume    = 3'd0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_code_vaild !== 1'b0 || o_queue_count !== 3'd0 || o_queue_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: vaild=%b count=%0d data=%h expected 0/0/0",
               o_code_vaild, o_queue_count, o_queue_data);
    end
    i_reset = 1'b0;
    checks++;
    if (o_code_vaild !== 1'b0) begin
      errors++;
      $display("[TB] FAIL vaild_first_cycle: got %b expected 0", o_code_vaild);
    end
    tick();
    checks++;
    if (o_code_vaild !== 1'b1 || o_code_address !== 32'hFFFF_FFF0) begin
      errors++;
      $display("[TB] FAIL first_request: vaild=%b addr=%h expected 1/fffffff0", o_code_vaild, o_code_address);
    end
  endtask

  task automatic test_first_fetch();
    respond(3, 32'h4433_2211, 3'd0);
    checks++;
    if (o_queue_count !== 3'd4 || o_queue_data !== 32'h4433_2211) begin
      errors++;
      $display("[TB] FAIL first_fetch_data: count=%0d data=%h expected 4/44332211", o_queue_count, o_queue_data);
    end
  endtask

  task automatic test_fill_and_wrap();
    logic [31:0] exp_addr;
    logic [31:0] w1;
    bit seen;
    exp_addr = 32'hFFFF_FFF4;
    w1 = $urandom;
    for (int k = 0; k < 3; k++) begin
      wait_req("fill");
      checks++;
      if (o_code_address !== exp_addr) begin
        errors++;
        $display("[TB] FAIL fill_addr: got %h expected %h", o_code_address, exp_addr);
      end
      respond(1, (k == 0) ? w1 : $urandom, 3'd0);
      exp_addr += 32'd4;
    end
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (o_code_vaild !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL no_fifth_request: request seen=1 expected 0 with full queue");
    end
    i_consume = 3'd4;
    tick();
    i_consume = 3'd0;
    checks++;
    if (o_queue_count !== 3'd4 || o_queue_data !== w1) begin
      errors++;
      $display("[TB] FAIL after_consume: count=%0d data=%h expected 4/%h", o_queue_count, o_queue_data, w1);
    end
    wait_req("wrap");
    checks++;
    if (o_code_address !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_addr: got %h expected 00000000", o_code_address);
    end
    respond(0, $urandom, 3'd0);
  endtask

  task automatic test_flush_idle();
    i_flush = 1'b1;
    i_flush_address = 32'h0000_1003;
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_queue_count !== 3'd0 || o_code_vaild !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_clears: count=%0d vaild=%b expected 0/0", o_queue_count, o_code_vaild);
    end
    tick();
    checks++;
    if (o_code_vaild !== 1'b1 || o_code_address !== 32'h0000_1000) begin
      errors++;
      $display("[TB] FAIL flush_request: vaild=%b addr=%h expected 1/00001000", o_code_vaild, o_code_address);
    end
    respond(0, 32'hDDCC_BBAA, 3'd0);
    checks++;
    if (o_queue_count !== 3'd1 || o_queue_data[7:0] !== 8'hDD) begin
      errors++;
      $display("[TB] FAIL misaligned_skip: count=%0d byte0=%h expected 1/dd", o_queue_count, o_queue_data[7:0]);
    end
  endtask

  task automatic test_flush_outstanding();
    bit held;
    i_flush = 1'b1;
    i_flush_address = 32'h0000_1000;
    tick();
    i_flush = 1'b0;
    wait_req("outstanding");
    checks++;
    if (o_code_address !== 32'h0000_1000) begin
      errors++;
      $display("[TB] FAIL outstanding_addr: got %h expected 00001000", o_code_address);
    end
    i_flush = 1'b1;
    i_flush_address = 32'h0000_2000;
    tick();
    i_flush = 1'b0;
    held = 1'b1;
    repeat (3) begin
      if (o_code_vaild !== 1'b1 || o_code_address !== 32'h0000_1000 || o_queue_count !== 3'd0) held = 1'b0;
      tick();
    end
    checks++;
    if (!held) begin
      errors++;
      $display("[TB] FAIL drain_hold: vaild=%b addr=%h expected 1/00001000 held", o_code_vaild, o_code_address);
    end
    i_code_ready = 1'b1;
    i_code_data_read = 32'hCAFE_F00D;
    tick();
    i_code_ready = 1'b0;
    checks++;
    if (o_queue_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL drain_discard: count=%0d expected 0", o_queue_count);
    end
    wait_req("redirect");
    checks++;
    if (o_code_address !== 32'h0000_2000) begin
      errors++;
      $display("[TB] FAIL redirect_addr: got %h expected 00002000", o_code_address);
    end
    respond(0, $urandom, 3'd0);
  endtask

  task automatic test_consume_with_write();
    i_flush = 1'b1;
    i_flush_address = 32'h0000_3002;
    tick();
    i_flush = 1'b0;
    wait_req("cw_first");
    respond(1, 32'hBBAA_0000, 3'd0);
    checks++;
    if (o_queue_count !== 3'd2 || o_queue_data[15:0] !== 16'hBBAA) begin
      errors++;
      $display("[TB] FAIL two_bytes: count=%0d data=%h expected 2/xxxxbbaa", o_queue_count, o_queue_data);
    end
    wait_req("cw_second");
    checks++;
    if (o_code_address !== 32'h0000_3004) begin
      errors++;
      $display("[TB] FAIL cw_addr: got %h expected 00003004", o_code_address);
    end
    respond(0, 32'h8877_6655, 3'd2);
    checks++;
    if (o_queue_count !== 3'd4 || o_queue_data !== 32'h8877_6655) begin
      errors++;
      $display("[TB] FAIL consume_with_write: count=%0d data=%h expected 4/88776655", o_queue_count, o_queue_data);
    end
  endtask

  task automatic test_clamp();
    i_flush = 1'b1;
    i_flush_address = 32'h0000_4003;
    tick();
    i_flush = 1'b0;
    wait_req("clamp_first");
    respond(0, 32'h5A00_0000, 3'd0);
    checks++;
    if (o_queue_count !== 3'd1 || o_queue_data[7:0] !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL clamp_setup: count=%0d byte0=%h expected 1/5a", o_queue_count, o_queue_data[7:0]);
    end
    i_consume = 3'd4;
    tick();
    i_consume = 3'd0;
    checks++;
    if (o_queue_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL clamp_count: count=%0d expected 0", o_queue_count);
    end
    wait_req("clamp_next");
    respond(0, 32'h0D0C_0B0A, 3'd0);
    checks++;
    if (o_queue_count !== 3'd4 || o_queue_data !== 32'h0D0C_0B0A) begin
      errors++;
      $display("[TB] FAIL clamp_recover: count=%0d data=%h expected 4/0d0c0b0a", o_queue_count, o_queue_data);
    end
  endtask

  task automatic test_reset_mid_fetch();
    wait_req("mid_fetch");
    i_reset = 1'b1;
    tick();
    checks++;
    if (o_code_vaild !== 1'b0 || o_queue_count !== 3'd0 || o_queue_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_fetch: vaild=%b count=%0d data=%h expected 0/0/0",
               o_code_vaild, o_queue_count, o_queue_data);
    end
    i_reset = 1'b0;
    tick();
    checks++;
    if (o_code_vaild !== 1'b1 || o_code_address !== 32'hFFFF_FFF0) begin
      errors++;
      $display("[TB] FAIL restart_addr: vaild=%b addr=%h expected 1/fffffff0", o_code_vaild, o_code_address);
    end
    respond(0, $urandom, 3'd0);
  endtask

  // Reference model: the queue is a list of bytes; requests are predicted by address.
  logic [7:0]  mq[$];
  logic [31:0] next_addr;
  logic [31:0] stale_addr;
  logic [1:0]  mskip;
  bit          stale;

  task automatic test_random();
    int exp_cnt, wait_cnt, lat_target, n;
    bit raw, must_req;
    logic [31:0] exp_d, mask, fa;
    i_reset = 1'b1;
    repeat (2) tick();
    i_reset = 1'b0;
    mq.delete();
    next_addr = 32'hFFFF_FFF0;
    mskip = 2'd0;
    stale = 1'b0;
    must_req = 1'b0;
    wait_cnt = 0;
    lat_target = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_code_ready = 1'b0;
      i_flush = 1'b0;
      i_consume = 3'd0;
      #1;
      raw = (o_code_vaild === 1'b1);
      exp_cnt = (mq.size() > 4) ? 4 : mq.size();
      exp_d = '0;
      mask = '0;
      for (int i = 0; i < exp_cnt; i++) begin
        exp_d[8*i +: 8] = mq[i];
        mask[8*i +: 8] = 8'hFF;
      end
      checks++;
      if (o_queue_count !== 3'(exp_cnt) || (o_queue_data & mask) !== exp_d) begin
        errors++;
        $display("[TB] FAIL rand_queue cyc %0d: count=%0d data=%h expected %0d/%h (mask %h)",
                 cyc, o_queue_count, o_queue_data, exp_cnt, exp_d, mask);
      end
      if (must_req) begin
        checks++;
        if (!raw) begin
          errors++;
          $display("[TB] FAIL rand_request_timing cyc %0d: vaild=%b expected 1", cyc, o_code_vaild);
        end
      end
      if (raw) begin
        checks++;
        if (o_code_address !== (stale ? stale_addr : next_addr) || (!stale && mq.size() > CAP - 4)) begin
          errors++;
          $display("[TB] FAIL rand_request cyc %0d: addr=%h expected %h (queued %0d)",
                   cyc, o_code_address, stale ? stale_addr : next_addr, mq.size());
        end
        if (wait_cnt >= lat_target) begin
          i_code_ready = 1'b1;
          i_code_data_read = $urandom;
          wait_cnt = 0;
          lat_target = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end
      i_consume = ((cyc % 512) < 128) ? 3'd0 : 3'($urandom_range(0, 4));
      if ($urandom_range(0, 24) == 0) begin
        i_flush = 1'b1;
        fa = $urandom;
        if ($urandom_range(0, 1) == 1) fa = fa | 32'hFFFF_FF00;
        i_flush_address = fa;
      end
      #1;
      if (i_code_ready) begin
        checks++;
        if (o_code_vaild !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand_vaild_with_ready cyc %0d: vaild=%b expected 0", cyc, o_code_vaild);
        end
      end
      must_req = !raw && !i_flush && (mq.size() <= CAP - 4);
      if (i_flush) begin
        mq.delete();
        if (raw && !i_code_ready) begin
          if (!stale) stale_addr = next_addr;
          stale = 1'b1;
        end else begin
          stale = 1'b0;
        end
        next_addr = {i_flush_address[31:2], 2'b00};
        mskip = i_flush_address[1:0];
      end else begin
        n = (i_consume > exp_cnt) ? exp_cnt : int'(i_consume);
        repeat (n) void'(mq.pop_front());
        if (i_code_ready) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            for (int j = mskip; j < 4; j++) mq.push_back(i_code_data_read[8*j +: 8]);
            next_addr = next_addr + 32'd4;
            mskip = 2'd0;
          end
        end
      end
      tick();
    end
    i_code_ready = 1'b0;
    i_flush = 1'b0;
    i_consume = 3'd0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fill_and_wrap();
    test_flush_idle();
    test_flush_outstanding();
    test_consume_with_write();
    test_clamp();
    test_reset_mid_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
